port_sel_scheduler: RTL and testbench
=====================================

PORT_SEL_SCHEDULER -- requirements
Module: port_sel_scheduler

Interface
REQ-001 SHALL have parameter NUM_PORTS, default 10, number of requesting ports (2..16).
REQ-002 SHALL have parameter SEL_WIDTH, default 4, width of sel; 2^SEL_WIDTH > NUM_PORTS.
REQ-003 SHALL have parameter BURST_LEN, default 4, max accepted beats per grant (1..16).
REQ-004 SHALL have port clk  input  1  single clock; all state on rising edge.
REQ-005 SHALL have port rst  input  1  reset; asynchronous, active-high.
REQ-006 SHALL have port req  input  NUM_PORTS  per-port request, bit i = port i has data.
REQ-007 SHALL have port ready  input  1  downstream mux stage accepts current beat.
REQ-008 SHALL have port sel  output  SEL_WIDTH  registered port index driving the mux select.
REQ-009 SHALL have port sel_valid  output  1  sel holds a granted port index.
REQ-010 SHALL have port grant  output  NUM_PORTS  registered one-hot of granted port; all-zero when idle.
REQ-011 SHALL have port burst_done  output  1  one-cycle pulse on the cycle after a burst ends.

Function
REQ-012 SHALL implement an FSM with states IDLE and BURST.
REQ-013 In IDLE, sel SHALL equal IDLE_SEL (all ones, 15 at default), an out-of-range code so the downstream mux outputs zero with valid low.
REQ-014 Round-robin pointer ptr SHALL select the first port j with req[j]=1, searching ptr, ptr+1, ... wrapping NUM_PORTS-1 -> 0.
REQ-015 IDLE with any req bit set at edge N SHALL load sel=j, grant bit j, sel_valid=1, beat_cnt=0, state BURST after edge N (one-cycle latency).
REQ-016 A beat SHALL be counted in BURST when ready=1 and req[sel]=1 in the same cycle; otherwise beat_cnt holds.
REQ-017 A burst SHALL end when a beat is counted with beat_cnt=BURST_LEN-1, or when req[sel]=0 (no beat counted that cycle).
REQ-018 At burst end ptr SHALL become sel+1, wrapping NUM_PORTS-1 -> 0.
REQ-019 At burst end, if any req bit is set, the next grant SHALL be picked with the updated ptr in the same cycle (back-to-back, no idle cycle); otherwise state IDLE, sel=IDLE_SEL, sel_valid=0, grant=0.
REQ-020 The just-finished port SHALL be regranted back-to-back only if it is the sole requester.
REQ-021 burst_done SHALL assert for exactly one cycle after each burst end, including back-to-back ends.
REQ-022 ready=0 SHALL stall the burst indefinitely without changing sel, grant or beat_cnt.
REQ-023 BURST_LEN=1 SHALL end every burst on its first counted beat.
REQ-024 beat_cnt SHALL be $clog2(BURST_LEN+1) bits and never exceed BURST_LEN-1.
REQ-025 sel SHALL never take a value in NUM_PORTS..IDLE_SEL-1.

Reset
REQ-026 rst asserted SHALL immediately force state IDLE, sel=IDLE_SEL, sel_valid=0, grant=0, burst_done=0, beat_cnt=0, ptr=0, including mid-burst.
REQ-027 First grant after rst deasserts SHALL occur no earlier than the first rising edge with rst low.

Structure
REQ-028 Package port_sched_pkg SHALL hold the state enum, NUM_PORTS default, IDLE_SEL constant and the round-robin wrap function.
REQ-029 Combinational sub-module rr_pick SHALL compute (found, index) from req and ptr; the FSM SHALL instantiate it once.

Verification
REQ-030 Reset then req=10'h004, ready=1 -> sel=2 one cycle later, 4 beats, burst_done pulse, sel=2 regranted (sole requester).
REQ-031 req=10'h3FF, ready=1 for 40 cycles -> grants 0,1,...,9 then 0, each 4 beats, no idle gap, no sel 10..14.
REQ-032 Grant on port 9, req=10'h201 -> after burst ptr wraps to 0, next sel=0.
REQ-033 Port 5 granted, ready=0 for 6 cycles -> sel/beat_cnt frozen; ready=1 -> burst ends after 4 counted beats.
REQ-034 Port 3 granted, req[3] drops after 2 beats with req=0 otherwise -> burst_done, IDLE, sel=15, sel_valid=0.
REQ-035 rst pulsed mid-burst on port 7 -> outputs at reset values asynchronously; next grant searches from port 0.

Source files
------------

// File: rtl/port_sched_pkg.sv
// Shared types and constants for the port select scheduler.
package port_sched_pkg;

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_BURST = 1'b1
  } sched_state_e;

  localparam int NUM_PORTS_DEF = 10;
  localparam int SEL_WIDTH_DEF = 4;
  localparam int BURST_LEN_DEF = 4;

  // Out-of-range select code; the downstream mux drives zero for it.
  localparam logic [SEL_WIDTH_DEF-1:0] IDLE_SEL = {SEL_WIDTH_DEF{1'b1}};

  // Next port index in round-robin order, wrapping n-1 back to 0.
  function automatic int rr_wrap(input int idx, input int n);
    int nxt;
    nxt = idx + 32'sd1;
    if (nxt >= n) begin
      nxt = 32'sd0;
    end else begin
      nxt = nxt;
    end
    return nxt;
  endfunction

endpackage

// File: rtl/port_sel_scheduler_rr_pick.sv
// Round-robin picker: first requesting port at or after ptr, wrapping.
module rr_pick
  import port_sched_pkg::*;
#(
  parameter int NUM_PORTS = NUM_PORTS_DEF,
  parameter int SEL_WIDTH = SEL_WIDTH_DEF
) (
  input  logic [NUM_PORTS-1:0] req,
  input  logic [SEL_WIDTH-1:0] ptr,
  output logic                 found,
  output logic [SEL_WIDTH-1:0] index
);

  logic [NUM_PORTS-1:0] rot_s;

  // Rotate requests so bit k is port (ptr+k) mod NUM_PORTS, then take the lowest set bit.
  always_comb begin
    int sum;
    rot_s = NUM_PORTS'({req, req} >> ptr);
    found = 1'b0;
    index = {SEL_WIDTH{1'b0}};
    sum   = 32'sd0;
    for (int k = 0; k < NUM_PORTS; k++) begin
      if (!found && rot_s[k]) begin
        found = 1'b1;
        sum   = int'(ptr) + k;
        if (sum >= NUM_PORTS) begin
          sum = sum - NUM_PORTS;
        end else begin
          sum = sum;
        end
        index = SEL_WIDTH'(sum);
      end else begin
        found = found;
      end
    end
  end

endmodule

// File: rtl/port_sel_scheduler.sv
// Burst-oriented round-robin scheduler driving a registered mux select.
module port_sel_scheduler
  import port_sched_pkg::*;
#(
  parameter int NUM_PORTS = NUM_PORTS_DEF,
  parameter int SEL_WIDTH = SEL_WIDTH_DEF,
  parameter int BURST_LEN = BURST_LEN_DEF
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NUM_PORTS-1:0] req,
  input  logic                 ready,
  output logic [SEL_WIDTH-1:0] sel,
  output logic                 sel_valid,
  output logic [NUM_PORTS-1:0] grant,
  output logic                 burst_done
);

  localparam int CNT_W = $clog2(BURST_LEN + 1);
  localparam logic [SEL_WIDTH-1:0] SEL_IDLE = {SEL_WIDTH{1'b1}};
  localparam logic [CNT_W-1:0]     CNT_LAST = CNT_W'(BURST_LEN - 1);

  sched_state_e         state_r, state_nxt_s;
  logic [SEL_WIDTH-1:0] sel_r, sel_nxt_s;
  logic [NUM_PORTS-1:0] grant_r, grant_nxt_s;
  logic                 sel_valid_r, sel_valid_nxt_s;
  logic                 burst_done_r, burst_done_nxt_s;
  logic [CNT_W-1:0]     beat_cnt_r, beat_cnt_nxt_s;
  logic [SEL_WIDTH-1:0] ptr_r, ptr_nxt_s;

  logic                 req_sel_s, beat_s, burst_end_s;
  logic [SEL_WIDTH-1:0] pick_ptr_s, pick_idx_s;
  logic                 found_s;

  rr_pick #(
    .NUM_PORTS (NUM_PORTS),
    .SEL_WIDTH (SEL_WIDTH)
  ) u_rr_pick (
    .req   (req),
    .ptr   (pick_ptr_s),
    .found (found_s),
    .index (pick_idx_s)
  );

  // State and output registers; reset forces the idle picture at once.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r      <= ST_IDLE;
      sel_r        <= SEL_IDLE;
      grant_r      <= {NUM_PORTS{1'b0}};
      sel_valid_r  <= 1'b0;
      burst_done_r <= 1'b0;
      beat_cnt_r   <= {CNT_W{1'b0}};
      ptr_r        <= {SEL_WIDTH{1'b0}};
    end else begin
      state_r      <= state_nxt_s;
      sel_r        <= sel_nxt_s;
      grant_r      <= grant_nxt_s;
      sel_valid_r  <= sel_valid_nxt_s;
      burst_done_r <= burst_done_nxt_s;
      beat_cnt_r   <= beat_cnt_nxt_s;
      ptr_r        <= ptr_nxt_s;
    end
  end

  // Beat and burst-end detection; at burst end the picker already sees the advanced pointer.
  always_comb begin
    req_sel_s = |(req & grant_r);
    if (state_r == ST_BURST) begin
      beat_s      = ready & req_sel_s;
      burst_end_s = !req_sel_s || (beat_s && (beat_cnt_r == CNT_LAST));
    end else begin
      beat_s      = 1'b0;
      burst_end_s = 1'b0;
    end
    if (burst_end_s) begin
      pick_ptr_s = SEL_WIDTH'(rr_wrap(int'(sel_r), NUM_PORTS));
    end else begin
      pick_ptr_s = ptr_r;
    end
  end

  // Next-state logic.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_IDLE:  state_nxt_s = found_s ? ST_BURST : ST_IDLE;
      ST_BURST: state_nxt_s = (burst_end_s && !found_s) ? ST_IDLE : ST_BURST;
      default:  state_nxt_s = ST_IDLE;
    endcase
  end

  // Next values of the registered outputs, counter and pointer.
  always_comb begin
    sel_nxt_s        = sel_r;
    grant_nxt_s      = grant_r;
    sel_valid_nxt_s  = sel_valid_r;
    beat_cnt_nxt_s   = beat_cnt_r;
    ptr_nxt_s        = ptr_r;
    burst_done_nxt_s = burst_end_s;
    case (state_r)
      ST_IDLE, ST_BURST: begin
        if ((state_r == ST_IDLE) || burst_end_s) begin
          ptr_nxt_s = pick_ptr_s;
          if (found_s) begin
            sel_nxt_s       = pick_idx_s;
            grant_nxt_s     = {{(NUM_PORTS-1){1'b0}}, 1'b1} << pick_idx_s;
            sel_valid_nxt_s = 1'b1;
            beat_cnt_nxt_s  = {CNT_W{1'b0}};
          end else begin
            sel_nxt_s       = SEL_IDLE;
            grant_nxt_s     = {NUM_PORTS{1'b0}};
            sel_valid_nxt_s = 1'b0;
            beat_cnt_nxt_s  = {CNT_W{1'b0}};
          end
        end else if (beat_s) begin
          beat_cnt_nxt_s = beat_cnt_r + CNT_W'(1);
        end else begin
          beat_cnt_nxt_s = beat_cnt_r;
        end
      end
      default: begin
        sel_nxt_s       = SEL_IDLE;
        grant_nxt_s     = {NUM_PORTS{1'b0}};
        sel_valid_nxt_s = 1'b0;
        beat_cnt_nxt_s  = {CNT_W{1'b0}};
        ptr_nxt_s       = {SEL_WIDTH{1'b0}};
      end
    endcase
  end

  assign sel        = sel_r;
  assign sel_valid  = sel_valid_r;
  assign grant      = grant_r;
  assign burst_done = burst_done_r;

endmodule

// File: tb/tb_port_sel_scheduler.sv
// Directed and random stimulus against a cycle-level behavioural model of the scheduler.
module tb_port_sel_scheduler;

  localparam int N  = 10;
  localparam int BL = 4;

  logic         clk = 1'b0;
  logic         rst;
  logic [N-1:0] req;
  logic         ready;
  logic [3:0]   sel;
  logic         sel_valid;
  logic [N-1:0] grant;
  logic         burst_done;

  int n_checks = 0;
  int n_fail   = 0;

  // Model: currently granted port (-1 = idle), beats taken, pointer, done pulse.
  int m_port, m_beats, m_ptr;
  bit m_done;

  port_sel_scheduler #(.NUM_PORTS(N), .SEL_WIDTH(4), .BURST_LEN(BL)) dut (
    .clk        (clk),
    .rst        (rst),
    .req        (req),
    .ready      (ready),
    .sel        (sel),
    .sel_valid  (sel_valid),
    .grant      (grant),
    .burst_done (burst_done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_pick();
    for (int k = 0; k < N; k++) begin
      int j;
      j = (m_ptr + k) % N;
      if (req[j]) begin
        m_port  = j;
        m_beats = 0;
        return;
      end
    end
  endtask

  task automatic model_step();
    bit ended;
    ended  = 0;
    m_done = 0;
    if (m_port < 0) begin
      model_pick();
    end else begin
      if (req[m_port]) begin
        if (ready) begin
          m_beats++;
          if (m_beats == BL) ended = 1;
        end
      end else begin
        ended = 1;
      end
      if (ended) begin
        m_done  = 1;
        m_ptr   = (m_port + 1) % N;
        m_port  = -1;
        m_beats = 0;
        model_pick();
      end
    end
  endtask

  task automatic check_outputs(input string tag);
    logic [31:0] e_sel, e_grant;
    e_sel   = (m_port < 0) ? 32'd15 : 32'(m_port);
    e_grant = (m_port < 0) ? 32'd0 : (32'd1 << m_port);
    chk({tag, "_sel"},   32'(sel), e_sel);
    chk({tag, "_valid"}, 32'(sel_valid), (m_port < 0) ? 32'd0 : 32'd1);
    chk({tag, "_grant"}, 32'(grant), e_grant);
    chk({tag, "_done"},  32'(burst_done), 32'(m_done));
    chk({tag, "_range"}, 32'((sel < 4'd10) || (sel == 4'd15)), 32'd1);
  endtask

  task automatic cycle(input string tag, input logic [N-1:0] r, input logic rd);
    req   = r;
    ready = rd;
    model_step();
    @(posedge clk);
    #1;
    check_outputs(tag);
  endtask

  task automatic do_reset(input string tag);
    rst = 1'b1;
    #1;
    m_port = -1; m_beats = 0; m_ptr = 0; m_done = 0;
    check_outputs({tag, "_async"});
    @(posedge clk);
    #1;
    check_outputs({tag, "_held"});
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1; req = '0; ready = 1'b0;
    m_port = -1; m_beats = 0; m_ptr = 0; m_done = 0;

    // Reset state
    do_reset("rst0");

    // Single requester: grant port 2, four beats, pulse, regrant
    cycle("sole", 10'h004, 1'b1);
    chk("sole_first_sel", 32'(sel), 32'd2);
    for (int i = 0; i < 6; i++) cycle("sole", 10'h004, 1'b1);

    // All requesting: full rotation 0..9 then 0, back-to-back
    do_reset("rst1");
    for (int i = 0; i < 44; i++) cycle("all", 10'h3FF, 1'b1);

    // Wrap from port 9 to port 0
    do_reset("rst2");
    cycle("wrap", 10'h200, 1'b1);
    chk("wrap_sel9", 32'(sel), 32'd9);
    for (int i = 0; i < 4; i++) cycle("wrap", 10'h201, 1'b1);
    chk("wrap_sel0", 32'(sel), 32'd0);
    chk("wrap_done", 32'(burst_done), 32'd1);

    // Stall on port 5
    do_reset("rst3");
    cycle("stall", 10'h020, 1'b1);
    for (int i = 0; i < 6; i++) begin
      cycle("stall", 10'h020, 1'b0);
      chk("stall_frozen", 32'(sel), 32'd5);
    end
    for (int i = 0; i < 3; i++) cycle("stall", 10'h020, 1'b1);
    chk("stall_not_done", 32'(burst_done), 32'd0);
    cycle("stall", 10'h020, 1'b1);
    chk("stall_done", 32'(burst_done), 32'd1);

    // Early end on port 3 with nobody else requesting
    do_reset("rst4");
    cycle("drop", 10'h008, 1'b1);
    for (int i = 0; i < 2; i++) cycle("drop", 10'h008, 1'b1);
    cycle("drop", 10'h000, 1'b1);
    chk("drop_sel", 32'(sel), 32'd15);
    chk("drop_valid", 32'(sel_valid), 32'd0);
    chk("drop_done", 32'(burst_done), 32'd1);
    cycle("drop", 10'h000, 1'b1);

    // Reset mid-burst on port 7; next search starts at port 0
    do_reset("rst5");
    cycle("mid", 10'h080, 1'b1);
    cycle("mid", 10'h081, 1'b1);
    cycle("mid", 10'h081, 1'b1);
    do_reset("midrst");
    cycle("mid", 10'h081, 1'b1);
    chk("mid_sel0", 32'(sel), 32'd0);

    // Random traffic
    do_reset("rst6");
    for (int i = 0; i < 2000; i++) begin
      logic [N-1:0] r;
      r = req;
      if ($urandom_range(0, 3) == 0) r = N'($urandom & $urandom);
      if ($urandom_range(0, 15) == 0) r = '0;
      cycle("rand", r, ($urandom_range(0, 3) != 0));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
